// File: rtl/checkout_pkg.sv
// Shared types and default constants for the checkout scanner.
// Holds the scanner state encoding, the default item-code and counter widths,
// and the default discount / expensive lookup masks (one bit per item code).
package checkout_pkg;

  // Scanner control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCANNING = 2'd1,
    ALARM    = 2'd2
  } state_e;

  localparam int DEF_UPC_W = 3;
  localparam int DEF_CNT_W = 8;

  // Bit i set means item code i is discounted
  localparam logic [7:0] DEF_DISC_MASK = 8'b0011_0010;
  // Bit i set means item code i is expensive and must carry a mark
  localparam logic [7:0] DEF_EXP_MASK  = 8'b1100_0001;

endpackage

// File: rtl/checkout_scanner_upc_classifier.sv
// Purely combinational item classifier.
// Ports:
//   upc    in  UPC_W  item code
//   marked in  1      item carries a paid/security mark
//   disc   out 1      item code is in the discount mask
//   stolen out 1      item code is expensive and the item is unmarked
import checkout_pkg::*;

module upc_classifier #(
  parameter int                   UPC_W     = DEF_UPC_W,
  parameter logic [2**UPC_W-1:0]  DISC_MASK = DEF_DISC_MASK,
  parameter logic [2**UPC_W-1:0]  EXP_MASK  = DEF_EXP_MASK
) (
  input  logic [UPC_W-1:0] upc,
  input  logic             marked,
  output logic             disc,
  output logic             stolen
);

  assign disc   = DISC_MASK[upc];
  assign stolen = EXP_MASK[upc] & ~marked;

endmodule

// File: rtl/checkout_scanner.sv
// Checkout scanner: accepts one item per valid/ready handshake, classifies it,
// keeps saturating per-transaction counts, publishes totals on checkout and
// latches a theft alarm that blocks scanning until acknowledged.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   scan_valid / scan_ready          item handshake (ready low while alarmed)
//   upc, marked                      item code and mark flag
//   checkout                         pulse: close the transaction
//   alarm_clr                        pulse: acknowledge the alarm
//   alarm                            latched theft alarm
//   last_disc, last_stolen           classification of last accepted item
//   item_cnt, disc_cnt, stolen_cnt   live transaction counts
//   done                             one-cycle pulse when totals update
//   total_items/disc/stolen          totals of the last closed transaction
import checkout_pkg::*;

module checkout_scanner #(
  parameter int                   UPC_W     = DEF_UPC_W,
  parameter int                   CNT_W     = DEF_CNT_W,
  parameter logic [2**UPC_W-1:0]  DISC_MASK = DEF_DISC_MASK,
  parameter logic [2**UPC_W-1:0]  EXP_MASK  = DEF_EXP_MASK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_valid,
  output logic             scan_ready,
  input  logic [UPC_W-1:0] upc,
  input  logic             marked,
  input  logic             checkout,
  input  logic             alarm_clr,
  output logic             alarm,
  output logic             last_disc,
  output logic             last_stolen,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [CNT_W-1:0] stolen_cnt,
  output logic             done,
  output logic [CNT_W-1:0] total_items,
  output logic [CNT_W-1:0] total_disc,
  output logic [CNT_W-1:0] total_stolen
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] itemCnt_q, itemCnt_d;
  logic [CNT_W-1:0] discCnt_q, discCnt_d;
  logic [CNT_W-1:0] stolenCnt_q, stolenCnt_d;
  logic [CNT_W-1:0] totItems_q, totItems_d;
  logic [CNT_W-1:0] totDisc_q, totDisc_d;
  logic [CNT_W-1:0] totStolen_q, totStolen_d;
  logic             lastDisc_q, lastDisc_d;
  logic             lastStolen_q, lastStolen_d;
  logic             done_q, done_d;

  logic             disc, stolen, acc;
  logic [CNT_W-1:0] itemInc, discInc, stolenInc;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  upc_classifier #(
    .UPC_W     (UPC_W),
    .DISC_MASK (DISC_MASK),
    .EXP_MASK  (EXP_MASK)
  ) u_classifier (
    .upc    (upc),
    .marked (marked),
    .disc   (disc),
    .stolen (stolen)
  );

  assign scan_ready = (state_q != ALARM);
  assign acc        = scan_valid & scan_ready;

  // Counts including the item being accepted this cycle; these feed both the
  // live counters and the totals so a same-cycle item lands in the totals.
  assign itemInc   = satInc(itemCnt_q, acc);
  assign discInc   = satInc(discCnt_q, acc & disc);
  assign stolenInc = satInc(stolenCnt_q, acc & stolen);

  // Next-state logic. A stolen item takes priority over checkout, so the
  // transaction stays open and the alarm is raised with the item counted.
  always_comb begin
    state_d      = state_q;
    itemCnt_d    = itemCnt_q;
    discCnt_d    = discCnt_q;
    stolenCnt_d  = stolenCnt_q;
    totItems_d   = totItems_q;
    totDisc_d    = totDisc_q;
    totStolen_d  = totStolen_q;
    lastDisc_d   = lastDisc_q;
    lastStolen_d = lastStolen_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE, SCANNING: begin
        if (acc) begin
          itemCnt_d    = itemInc;
          discCnt_d    = discInc;
          stolenCnt_d  = stolenInc;
          lastDisc_d   = disc;
          lastStolen_d = stolen;
        end
        if (acc && stolen) begin
          state_d = ALARM;
        end else if (checkout) begin
          done_d       = 1'b1;
          totItems_d   = itemInc;
          totDisc_d    = discInc;
          totStolen_d  = stolenInc;
          itemCnt_d    = '0;
          discCnt_d    = '0;
          stolenCnt_d  = '0;
          lastDisc_d   = 1'b0;
          lastStolen_d = 1'b0;
          state_d      = IDLE;
        end else if (acc) begin
          state_d = SCANNING;
        end
      end
      ALARM: begin
        if (alarm_clr) begin
          state_d = SCANNING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      itemCnt_q    <= '0;
      discCnt_q    <= '0;
      stolenCnt_q  <= '0;
      totItems_q   <= '0;
      totDisc_q    <= '0;
      totStolen_q  <= '0;
      lastDisc_q   <= 1'b0;
      lastStolen_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      itemCnt_q    <= itemCnt_d;
      discCnt_q    <= discCnt_d;
      stolenCnt_q  <= stolenCnt_d;
      totItems_q   <= totItems_d;
      totDisc_q    <= totDisc_d;
      totStolen_q  <= totStolen_d;
      lastDisc_q   <= lastDisc_d;
      lastStolen_q <= lastStolen_d;
      done_q       <= done_d;
    end
  end

  assign alarm        = (state_q == ALARM);
  assign last_disc    = lastDisc_q;
  assign last_stolen  = lastStolen_q;
  assign item_cnt     = itemCnt_q;
  assign disc_cnt     = discCnt_q;
  assign stolen_cnt   = stolenCnt_q;
  assign done         = done_q;
  assign total_items  = totItems_q;
  assign total_disc   = totDisc_q;
  assign total_stolen = totStolen_q;

endmodule

// File: tb/tb_checkout_scanner.sv
// Testbench for checkout_scanner. Two instances share the same stimulus:
// dutA with 8-bit counters and dutB with 2-bit counters, so saturation
// behaviour is exercised alongside the normal flows.
module tb_checkout_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_valid;
  logic [2:0] upc;
  logic       marked;
  logic       checkout;
  logic       alarm_clr;

  logic       aReady, aAlarm, aLastDisc, aLastStolen, aDone;
  logic [7:0] aItemCnt, aDiscCnt, aStolenCnt, aTotItems, aTotDisc, aTotStolen;
  logic       bReady, bAlarm, bLastDisc, bLastStolen, bDone;
  logic [1:0] bItemCnt, bDiscCnt, bStolenCnt, bTotItems, bTotDisc, bTotStolen;

  int checkCnt = 0;
  int passCnt  = 0;

  // Item tables as read from the lab sheet: code -> discounted / expensive
  logic [7:0] discTable = 8'b0011_0010;
  logic [7:0] expTable  = 8'b1100_0001;

  // Behavioural model: unbounded true counts, clamped only when compared
  int mItems, mDisc, mStolen;
  int mTotItems, mTotDisc, mTotStolen;
  bit mLastDisc, mLastStolen, mAlarm, mDone;

  always #5 clk = ~clk;

  checkout_scanner #(.UPC_W(3), .CNT_W(8)) dutA (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(aReady),
    .upc(upc), .marked(marked), .checkout(checkout), .alarm_clr(alarm_clr),
    .alarm(aAlarm), .last_disc(aLastDisc), .last_stolen(aLastStolen),
    .item_cnt(aItemCnt), .disc_cnt(aDiscCnt), .stolen_cnt(aStolenCnt),
    .done(aDone), .total_items(aTotItems), .total_disc(aTotDisc),
    .total_stolen(aTotStolen)
  );

  checkout_scanner #(.UPC_W(3), .CNT_W(2)) dutB (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(bReady),
    .upc(upc), .marked(marked), .checkout(checkout), .alarm_clr(alarm_clr),
    .alarm(bAlarm), .last_disc(bLastDisc), .last_stolen(bLastStolen),
    .item_cnt(bItemCnt), .disc_cnt(bDiscCnt), .stolen_cnt(bStolenCnt),
    .done(bDone), .total_items(bTotItems), .total_disc(bTotDisc),
    .total_stolen(bTotStolen)
  );

  function automatic int clampTo(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mItems = 0; mDisc = 0; mStolen = 0;
    mTotItems = 0; mTotDisc = 0; mTotStolen = 0;
    mLastDisc = 0; mLastStolen = 0; mAlarm = 0; mDone = 0;
  endtask

  // One clock of the checkout rules applied to the inputs held that cycle
  task automatic modelStep(input bit v, input logic [2:0] u, input bit m,
                           input bit co, input bit clr);
    bit isDisc, isStolen;
    isDisc   = discTable[u];
    isStolen = expTable[u] && !m;
    mDone    = 0;
    if (mAlarm) begin
      if (clr) mAlarm = 0;
    end else begin
      if (v) begin
        mItems      = mItems + 1;
        mDisc       = mDisc + (isDisc ? 1 : 0);
        mStolen     = mStolen + (isStolen ? 1 : 0);
        mLastDisc   = isDisc;
        mLastStolen = isStolen;
      end
      if (v && isStolen) begin
        mAlarm = 1;
      end else if (co) begin
        mTotItems  = mItems;
        mTotDisc   = mDisc;
        mTotStolen = mStolen;
        mItems = 0; mDisc = 0; mStolen = 0;
        mLastDisc = 0; mLastStolen = 0;
        mDone = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, let the DUT clock them, advance the model
  task automatic applyStimulus(input bit v, input logic [2:0] u, input bit m,
                               input bit co, input bit clr);
    scan_valid = v; upc = u; marked = m; checkout = co; alarm_clr = clr;
    @(posedge clk);
    modelStep(v, u, m, co, clr);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 3'd0, 0, 0, 0);
  endtask

  // Every falling edge: both instances against the model
  always @(negedge clk) begin
    checkOutput("a.scan_ready",   aReady,      !mAlarm);
    checkOutput("a.alarm",        aAlarm,      mAlarm);
    checkOutput("a.last_disc",    aLastDisc,   mLastDisc);
    checkOutput("a.last_stolen",  aLastStolen, mLastStolen);
    checkOutput("a.item_cnt",     aItemCnt,    clampTo(mItems, 255));
    checkOutput("a.disc_cnt",     aDiscCnt,    clampTo(mDisc, 255));
    checkOutput("a.stolen_cnt",   aStolenCnt,  clampTo(mStolen, 255));
    checkOutput("a.done",         aDone,       mDone);
    checkOutput("a.total_items",  aTotItems,   clampTo(mTotItems, 255));
    checkOutput("a.total_disc",   aTotDisc,    clampTo(mTotDisc, 255));
    checkOutput("a.total_stolen", aTotStolen,  clampTo(mTotStolen, 255));
    checkOutput("b.scan_ready",   bReady,      !mAlarm);
    checkOutput("b.alarm",        bAlarm,      mAlarm);
    checkOutput("b.item_cnt",     bItemCnt,    clampTo(mItems, 3));
    checkOutput("b.disc_cnt",     bDiscCnt,    clampTo(mDisc, 3));
    checkOutput("b.stolen_cnt",   bStolenCnt,  clampTo(mStolen, 3));
    checkOutput("b.done",         bDone,       mDone);
    checkOutput("b.total_items",  bTotItems,   clampTo(mTotItems, 3));
    checkOutput("b.total_disc",   bTotDisc,    clampTo(mTotDisc, 3));
    checkOutput("b.total_stolen", bTotStolen,  clampTo(mTotStolen, 3));
  end

  initial begin
    reset_n = 1'b0;
    scan_valid = 0; upc = 3'd0; marked = 0; checkout = 0; alarm_clr = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checkOutput("reset.scan_ready", aReady, 1);
    checkOutput("reset.alarm", aAlarm, 0);
    checkOutput("reset.item_cnt", aItemCnt, 0);

    $display("[TB] discounted flow");
    applyStimulus(1, 3'd1, 0, 0, 0);
    applyStimulus(1, 3'd4, 0, 0, 0);
    applyStimulus(1, 3'd2, 0, 0, 0);
    checkOutput("disc.item_cnt_live", aItemCnt, 3);
    applyStimulus(0, 3'd0, 0, 1, 0);
    checkOutput("disc.done", aDone, 1);
    checkOutput("disc.total_items", aTotItems, 3);
    checkOutput("disc.total_disc", aTotDisc, 2);
    checkOutput("disc.total_stolen", aTotStolen, 0);
    checkOutput("disc.item_cnt_cleared", aItemCnt, 0);
    idle();
    checkOutput("disc.done_pulse_ends", aDone, 0);

    $display("[TB] theft");
    applyStimulus(1, 3'd7, 0, 0, 0);
    checkOutput("theft.alarm", aAlarm, 1);
    checkOutput("theft.last_stolen", aLastStolen, 1);
    checkOutput("theft.stolen_cnt", aStolenCnt, 1);
    checkOutput("theft.scan_ready", aReady, 0);
    applyStimulus(1, 3'd3, 0, 0, 0);
    checkOutput("theft.blocked_item_cnt", aItemCnt, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    checkOutput("theft.checkout_ignored", aDone, 0);
    applyStimulus(0, 3'd0, 0, 0, 1);
    checkOutput("theft.cleared_ready", aReady, 1);
    checkOutput("theft.cleared_alarm", aAlarm, 0);
    applyStimulus(0, 3'd0, 0, 1, 0);
    checkOutput("theft.total_stolen", aTotStolen, 1);
    idle();

    $display("[TB] marked expensive item");
    applyStimulus(1, 3'd0, 1, 0, 0);
    checkOutput("marked.last_stolen", aLastStolen, 0);
    checkOutput("marked.alarm", aAlarm, 0);
    checkOutput("marked.item_cnt", aItemCnt, 1);
    applyStimulus(0, 3'd0, 0, 0, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    idle();

    $display("[TB] same-cycle scan and checkout");
    applyStimulus(1, 3'd5, 0, 1, 0);
    checkOutput("same.done", aDone, 1);
    checkOutput("same.total_items", aTotItems, 1);
    checkOutput("same.total_disc", aTotDisc, 1);
    idle();
    applyStimulus(1, 3'd1, 0, 0, 0);
    applyStimulus(1, 3'd6, 0, 1, 0);
    checkOutput("same_stolen.alarm", aAlarm, 1);
    checkOutput("same_stolen.no_done", aDone, 0);
    checkOutput("same_stolen.item_cnt", aItemCnt, 2);
    applyStimulus(0, 3'd0, 0, 0, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    idle();

    $display("[TB] saturation");
    for (int i = 0; i < 6; i++) applyStimulus(1, 3'd1, 0, 0, 0);
    checkOutput("sat.b_item_cnt", bItemCnt, 3);
    checkOutput("sat.b_disc_cnt", bDiscCnt, 3);
    applyStimulus(0, 3'd0, 0, 1, 0);
    checkOutput("sat.b_total_items", bTotItems, 3);
    checkOutput("sat.b_total_disc", bTotDisc, 3);
    checkOutput("sat.a_total_items", aTotItems, 6);
    idle();

    $display("[TB] reset mid-transaction");
    applyStimulus(1, 3'd4, 0, 0, 0);
    applyStimulus(0, 3'd0, 0, 0, 0);
    #2 reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset.item_cnt", aItemCnt, 0);
    checkOutput("async_reset.last_disc", aLastDisc, 0);
    checkOutput("async_reset.total_items", aTotItems, 0);
    checkOutput("async_reset.scan_ready", aReady, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1, 3'd5, 0, 0, 0);
    applyStimulus(0, 3'd0, 0, 0, 1);
    checkOutput("post_reset.clr_ignored_ready", aReady, 1);
    applyStimulus(0, 3'd0, 0, 1, 0);
    idle();
    idle();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
